// File: rtl/audio_filter_pkg.sv
// Shared constants, types and helpers for the audio FIR filter and its output FIFO.
// Coefficients are Q1.15; the default set is a 16-tap moving average.
package audio_filter_pkg;

  localparam int DATA_W = 16;
  localparam int TAPS   = 16;
  localparam int DEPTH  = 16;
  localparam int FRAC   = 15;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int TAP_W  = $clog2(TAPS);

  typedef logic signed [DATA_W-1:0] sample_t;

  localparam sample_t COEF [TAPS] = '{default: 16'sh0800};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } filt_state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  // Rescale the Q-format accumulator back to a sample and clamp to the sample range.
  function automatic sample_t sat_sample(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> FRAC;
    if (shifted > SAT_MAX)      return 16'sh7FFF;
    else if (shifted < SAT_MIN) return 16'sh8000;
    else                        return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous show-ahead FIFO for filtered samples. Writes into a full FIFO and
// reads from an empty one are ignored; the head reads as 0 while empty.
module audio_sample_fifo
  import audio_filter_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH_P = DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH_P);

  logic [W-1:0]     mem [DEPTH_P];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH_P));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH_P is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_filter_fifo.sv
// Audio FIR filter with a sequential single-multiplier MAC feeding a show-ahead
// output FIFO. Handshake: sample_end is a 1-cycle strobe, filter_finish a 1-cycle pulse.
module audio_filter_fifo
  import audio_filter_pkg::*;
(
  input  logic              audio_clk,
  input  logic              reset,
  input  logic              sample_end,
  input  logic [DATA_W-1:0] audio_input,
  output logic [DATA_W-1:0] filter_output,
  output logic              filter_finish,
  input  logic              fifo_rdreq,
  output logic [DATA_W-1:0] fifo_q,
  output logic              fifo_empty,
  output logic              fifo_full,
  output filt_state_e       dbg_state
);

  sample_t                 hist [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic [TAP_W-1:0]        tap;
  logic signed [PROD_W-1:0] prod;
  filt_state_e             state;
  filt_state_e             next_state;

  assign dbg_state = state;
  assign prod      = PROD_W'(hist[tap]) * PROD_W'(COEF[tap]);

  // A new sample always wins: it restarts the MAC and discards any partial result.
  always_comb begin
    next_state = state;
    if (sample_end) begin
      next_state = ST_MAC;
    end else begin
      case (state)
        ST_MAC:  if (tap == TAP_W'(TAPS-1)) next_state = ST_OUT;
        ST_OUT:  next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge audio_clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      acc           <= '0;
      tap           <= '0;
      filter_output <= '0;
      filter_finish <= 1'b0;
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else begin
      state         <= next_state;
      filter_finish <= 1'b0;
      if (sample_end) begin
        hist[0] <= audio_input;
        for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
        acc <= '0;
        tap <= '0;
      end else begin
        case (state)
          ST_MAC: begin
            acc <= acc + ACC_W'(prod);
            tap <= tap + 1'b1;
          end
          ST_OUT: begin
            filter_output <= sat_sample(acc);
            filter_finish <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  audio_sample_fifo u_fifo (
    .clk     (audio_clk),
    .rst     (reset),
    .wr_en   (filter_finish),
    .wr_data (filter_output),
    .rd_en   (fifo_rdreq),
    .rd_data (fifo_q),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_audio_filter_fifo.sv
// Directed and randomized checks of the FIR filter and output FIFO against a
// sum-of-products filter model and a queue-based FIFO model.
module tb_audio_filter_fifo;

  localparam int TAPS_M  = 16;
  localparam int DEPTH_M = 16;
  localparam longint COEF_M = 2048;

  logic        audio_clk;
  logic        reset;
  logic        sample_end;
  logic [15:0] audio_input;
  logic [15:0] filter_output;
  logic        filter_finish;
  logic        fifo_rdreq;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_full;
  audio_filter_pkg::filt_state_e dbg_state;

  int tests = 0;
  int fails = 0;

  logic signed [15:0] hist_m [$];
  logic [15:0]        fifo_m [$];
  logic [15:0]        last_out;

  audio_filter_fifo dut (
    .audio_clk     (audio_clk),
    .reset         (reset),
    .sample_end    (sample_end),
    .audio_input   (audio_input),
    .filter_output (filter_output),
    .filter_finish (filter_finish),
    .fifo_rdreq    (fifo_rdreq),
    .fifo_q        (fifo_q),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .dbg_state     (dbg_state)
  );

  initial audio_clk = 1'b0;
  always #5 audio_clk = ~audio_clk;

  task automatic step();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // y[n] = sat(sum_i x[n-i]*c_i >> 15)
  function automatic logic [15:0] model_out();
    longint acc = 0;
    for (int i = 0; i < TAPS_M && i < hist_m.size(); i++)
      acc += longint'(hist_m[i]) * COEF_M;
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic check_fifo(input string tag);
    chk({tag, "_q"},     fifo_q,     (fifo_m.size() == 0) ? 16'h0 : fifo_m[0]);
    chk({tag, "_empty"}, fifo_empty, fifo_m.size() == 0);
    chk({tag, "_full"},  fifo_full,  fifo_m.size() == DEPTH_M);
  endtask

  task automatic strobe(input logic [15:0] x);
    sample_end  = 1'b1;
    audio_input = x;
    step();
    sample_end  = 1'b0;
    hist_m.push_front(x);
    if (hist_m.size() > TAPS_M) void'(hist_m.pop_back());
  endtask

  task automatic wait_finish();
    int  lat  = 0;
    bit  seen = 0;
    while (!seen && lat < 40) begin
      step();
      lat++;
      if (filter_finish) seen = 1;
    end
    last_out = model_out();
    chk("finish_latency", lat, TAPS_M + 1);
    chk("filter_output", filter_output, last_out);
  endtask

  // Write edge that follows the finish cycle, optionally popping on the same edge.
  task automatic commit(input bit pop);
    bit was_full;
    was_full   = (fifo_m.size() == DEPTH_M);
    fifo_rdreq = pop;
    step();
    fifo_rdreq = 1'b0;
    if (pop && fifo_m.size() > 0) void'(fifo_m.pop_front());
    if (!was_full) fifo_m.push_back(last_out);
    chk("finish_pulse_end", filter_finish, 1'b0);
    check_fifo("commit");
  endtask

  task automatic sample(input logic [15:0] x, input bit pop);
    strobe(x);
    wait_finish();
    commit(pop);
  endtask

  task automatic pop_one();
    fifo_rdreq = 1'b1;
    step();
    fifo_rdreq = 1'b0;
    if (fifo_m.size() > 0) void'(fifo_m.pop_front());
    check_fifo("pop");
  endtask

  task automatic drain();
    while (fifo_m.size() > 0) pop_one();
  endtask

  initial begin
    int extra;
    reset       = 1'b1;
    sample_end  = 1'b0;
    audio_input = '0;
    fifo_rdreq  = 1'b0;
    last_out    = '0;
    step();
    step();
    chk("rst_output", filter_output, 16'h0);
    chk("rst_finish", filter_finish, 1'b0);
    check_fifo("rst");
    reset = 1'b0;
    step();

    // Impulse: 16 outputs of 0x07FF then 0; pop on the write edge once 3 entries queue.
    sample(16'h7FFF, 1'b0);
    chk("impulse_first", last_out, 16'h07FF);
    for (int i = 0; i < 16; i++) sample(16'h0000, fifo_m.size() >= 3);
    chk("impulse_tail", filter_output, 16'h0000);
    drain();
    pop_one();

    // DC levels, including the most negative sample.
    for (int i = 0; i < 16; i++) sample(16'h1000, 1'b1);
    chk("dc_pos", filter_output, 16'h1000);
    for (int i = 0; i < 16; i++) sample(16'h8000, 1'b1);
    chk("dc_neg", filter_output, 16'h8000);
    drain();

    // Overflow: 20 results, no reads; the last four are dropped.
    for (int i = 0; i < 20; i++) begin
      sample(16'($urandom_range(0, 65535)), 1'b0);
      if (i == 15) chk("ovf_full16", fifo_full, 1'b1);
    end
    chk("ovf_count", fifo_m.size(), DEPTH_M);
    for (int i = 0; i < 16; i++) pop_one();
    chk("ovf_empty", fifo_empty, 1'b1);

    // Concurrent read and write with three entries queued.
    for (int i = 0; i < 3; i++) sample(16'($urandom_range(0, 65535)), 1'b0);
    sample(16'($urandom_range(0, 65535)), 1'b1);
    pop_one();
    pop_one();
    chk("conc_not_empty", fifo_empty, 1'b0);
    pop_one();
    chk("conc_empty", fifo_empty, 1'b1);
    pop_one();
    sample(16'h4000, 1'b0);
    drain();

    // Randomized amplitudes and read pattern.
    for (int i = 0; i < 40; i++) begin
      sample(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) pop_one();
    end
    drain();

    // Restart: second sample 5 edges after the first yields exactly one finish.
    extra = 0;
    strobe(16'h3000);
    for (int i = 0; i < 4; i++) begin
      step();
      if (filter_finish) extra++;
    end
    strobe(16'h2000);
    wait_finish();
    commit(1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (filter_finish) extra++;
    end
    chk("restart_single_finish", extra, 0);
    drain();

    // Reset in the middle of a computation.
    sample(16'h1234, 1'b0);
    strobe(16'h5555);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    #1;
    hist_m.delete();
    fifo_m.delete();
    chk("midrst_finish", filter_finish, 1'b0);
    chk("midrst_output", filter_output, 16'h0);
    check_fifo("midrst");
    step();
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (filter_finish) extra++;
    end
    chk("midrst_no_stale", extra, 0);
    check_fifo("midrst_after");
    sample(16'h7FFF, 1'b0);
    chk("midrst_clean_history", last_out, 16'h07FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
